// File: rtl/branch_hazard_ctrl.sv
// Decode-stage branch sequencer. Stalls IF/ID while a branch operand is still
// being produced in EX/MEM, selects MEM-stage forwarding for the comparer,
// issues PCSrcD/FlushD on the resolve cycle and keeps saturating
// branch / taken statistics.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no branch in flight; a hazard-free branch resolves right here
// STALL   | waiting for an EX/MEM producer; IF/ID held, bubble into EX
// RESOLVE | operands ready; branch decision issued this cycle
module branch_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             br_valid,
  input  logic [2:0]       CompareMode,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       writeregE,
  input  logic             regwriteE,
  input  logic             memtoregE,
  input  logic [4:0]       writeregM,
  input  logic             regwriteM,
  input  logic             memtoregM,
  input  logic             cmp_result,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             FlushD,
  output logic             PCSrcD,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  // Compare_* codes shared with the main decoder.
  localparam logic [2:0] CMP_NULL = 3'd0;
  localparam logic [2:0] CMP_BEQ  = 3'd1;
  localparam logic [2:0] CMP_BNE  = 3'd2;
  localparam logic [2:0] CMP_BLTZ = 3'd3;
  localparam logic [2:0] CMP_BGTZ = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STALL   = 2'd1,
    S_RESOLVE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  // Counts every stall cycle of the branch, including the detection cycle
  // spent in IDLE, so a depth-1 hazard goes straight from IDLE to RESOLVE.
  logic [1:0] stall_cnt_q, stall_cnt_d;

  logic       active;
  logic       use_rs, use_rt;
  logic [1:0] rs_dep, rt_dep, depth;
  logic       resolve, stall;

  // Decode the branch kind and the RAW dependence depth of its operands.
  always_comb begin
    active = br_valid && (CompareMode != CMP_NULL);
    use_rt = (CompareMode == CMP_BEQ) || (CompareMode == CMP_BNE);
    use_rs = use_rt || (CompareMode == CMP_BLTZ) || (CompareMode == CMP_BGTZ);

    rs_dep = 2'd0;
    if (use_rs && (rsD != 5'd0)) begin
      if (regwriteE && (writeregE == rsD))
        rs_dep = memtoregE ? 2'd2 : 2'd1;
      else if (regwriteM && memtoregM && (writeregM == rsD))
        rs_dep = 2'd1;
    end

    rt_dep = 2'd0;
    if (use_rt && (rtD != 5'd0)) begin
      if (regwriteE && (writeregE == rtD))
        rt_dep = memtoregE ? 2'd2 : 2'd1;
      else if (regwriteM && memtoregM && (writeregM == rtD))
        rt_dep = 2'd1;
    end

    depth = (rs_dep > rt_dep) ? rs_dep : rt_dep;
  end

  // State and stall counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      stall_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic; dependences are only sampled while in IDLE.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      S_IDLE: begin
        stall_cnt_d = 2'd0;
        if (active && (depth != 2'd0)) begin
          stall_cnt_d = depth;
          state_d     = (depth == 2'd1) ? S_RESOLVE : S_STALL;
        end
      end
      S_STALL: begin
        stall_cnt_d = stall_cnt_q - 2'd1;
        if (stall_cnt_q <= 2'd2)
          state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        stall_cnt_d = 2'd0;
        state_d     = S_IDLE;
      end
      default: begin
        stall_cnt_d = 2'd0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // Output logic; reset forces every control output low without a clock edge.
  always_comb begin
    resolve   = 1'b0;
    stall     = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushE    = 1'b0;
    FlushD    = 1'b0;
    PCSrcD    = 1'b0;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_IDLE: begin
          resolve = active && (depth == 2'd0);
          stall   = active && (depth != 2'd0);
        end
        S_STALL:   stall   = 1'b1;
        S_RESOLVE: resolve = 1'b1;
        default: ;
      endcase
      StallF = stall;
      StallD = stall;
      FlushE = stall;
      PCSrcD = resolve && cmp_result;
      FlushD = resolve && cmp_result;
      // Forwarding follows the operands whenever a branch is being handled.
      if (active || (state_q != S_IDLE)) begin
        ForwardAD = (rsD != 5'd0) && regwriteM && (rsD == writeregM);
        ForwardBD = use_rt && (rtD != 5'd0) && regwriteM && (rtD == writeregM);
      end
    end
  end

  // Saturating statistics, bumped once per resolved branch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (resolve) begin
      if (br_count != '1)
        br_count <= br_count + 1'b1;
      if (cmp_result && (taken_count != '1))
        taken_count <= taken_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: table vectors, directed multi-cycle sequences
// and random stimulus against a cycle-count reference model. A second
// instance with 2-bit counters exercises saturation.
module tb_branch_hazard_ctrl;

  localparam logic [2:0] M_NULL = 3'd0;
  localparam logic [2:0] M_BEQ  = 3'd1;
  localparam logic [2:0] M_BNE  = 3'd2;
  localparam logic [2:0] M_BLTZ = 3'd3;
  localparam logic [2:0] M_BGTZ = 3'd4;

  logic clk = 1'b0;
  logic reset_n;
  logic br_valid;
  logic [2:0] CompareMode;
  logic [4:0] rsD, rtD, writeregE, writeregM;
  logic regwriteE, memtoregE, regwriteM, memtoregM, cmp_result;

  logic StallF, StallD, FlushE, FlushD, PCSrcD, ForwardAD, ForwardBD;
  logic [15:0] br_count, taken_count;
  logic s_StallF, s_StallD, s_FlushE, s_FlushD, s_PCSrcD, s_ForwardAD, s_ForwardBD;
  logic [1:0] s_br_count, s_taken_count;

  int checks = 0;
  int failures = 0;

  // reference model: cycles left until the pending branch resolves (0 = idle)
  int m_seq, m_br, m_tk, m_sbr, m_stk;
  int n_seq, n_br, n_tk, n_sbr, n_stk;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .br_valid(br_valid), .CompareMode(CompareMode),
    .rsD(rsD), .rtD(rtD), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .writeregM(writeregM), .regwriteM(regwriteM),
    .memtoregM(memtoregM), .cmp_result(cmp_result),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .FlushD(FlushD),
    .PCSrcD(PCSrcD), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .br_count(br_count), .taken_count(taken_count)
  );

  branch_hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .br_valid(br_valid), .CompareMode(CompareMode),
    .rsD(rsD), .rtD(rtD), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .writeregM(writeregM), .regwriteM(regwriteM),
    .memtoregM(memtoregM), .cmp_result(cmp_result),
    .StallF(s_StallF), .StallD(s_StallD), .FlushE(s_FlushE), .FlushD(s_FlushD),
    .PCSrcD(s_PCSrcD), .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD),
    .br_count(s_br_count), .taken_count(s_taken_count)
  );

  typedef struct {
    logic       bv;
    logic [2:0] mode;
    logic [4:0] rs, rt, we;
    logic       rwe, mte;
    logic [4:0] wm;
    logic       rwm, mtm, cmp;
    logic       e_stall, e_pc, e_fd, e_fa, e_fb;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic bv, input logic [2:0] mode, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] we, input logic rwe,
                       input logic mte, input logic [4:0] wm, input logic rwm,
                       input logic mtm, input logic cmp);
    br_valid = bv; CompareMode = mode; rsD = rs; rtD = rt;
    writeregE = we; regwriteE = rwe; memtoregE = mte;
    writeregM = wm; regwriteM = rwm; memtoregM = mtm; cmp_result = cmp;
  endtask

  task automatic drive_idle();
    drive(1'b0, M_NULL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic int dep_of(input logic [4:0] r);
    if (r == 5'd0) return 0;
    if (regwriteE && writeregE == r) return memtoregE ? 2 : 1;
    if (regwriteM && memtoregM && writeregM == r) return 1;
    return 0;
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Compare DUT outputs with the model for the current cycle, stage next state.
  task automatic model_check(input string tag);
    bit active, use_rt, use_rs, res, stl, fwd_en, fa, fb;
    int d;
    active = br_valid && CompareMode != M_NULL;
    use_rt = (CompareMode == M_BEQ) || (CompareMode == M_BNE);
    use_rs = use_rt || (CompareMode == M_BLTZ) || (CompareMode == M_BGTZ);
    d = 0;
    if (use_rs && dep_of(rsD) > d) d = dep_of(rsD);
    if (use_rt && dep_of(rtD) > d) d = dep_of(rtD);
    res = (m_seq == 0 && active && d == 0) || (m_seq == 1);
    stl = (m_seq == 0 && active && d > 0) || (m_seq > 1);
    fwd_en = (m_seq > 0) || active;
    fa = fwd_en && rsD != 0 && regwriteM && rsD == writeregM;
    fb = fwd_en && use_rt && rtD != 0 && regwriteM && rtD == writeregM;
    chk({tag, ".StallF"}, {31'd0, StallF}, {31'd0, stl});
    chk({tag, ".StallD"}, {31'd0, StallD}, {31'd0, stl});
    chk({tag, ".FlushE"}, {31'd0, FlushE}, {31'd0, stl});
    chk({tag, ".PCSrcD"}, {31'd0, PCSrcD}, {31'd0, res && cmp_result});
    chk({tag, ".FlushD"}, {31'd0, FlushD}, {31'd0, res && cmp_result});
    chk({tag, ".ForwardAD"}, {31'd0, ForwardAD}, {31'd0, fa});
    chk({tag, ".ForwardBD"}, {31'd0, ForwardBD}, {31'd0, fb});
    chk({tag, ".br_count"}, {16'd0, br_count}, m_br);
    chk({tag, ".taken_count"}, {16'd0, taken_count}, m_tk);
    chk({tag, ".sat_br"}, {30'd0, s_br_count}, m_sbr);
    chk({tag, ".sat_taken"}, {30'd0, s_taken_count}, m_stk);
    chk({tag, ".sat_StallF"}, {31'd0, s_StallF}, {31'd0, stl});
    if (m_seq > 0) n_seq = m_seq - 1;
    else if (active && d > 0) n_seq = d;
    else n_seq = 0;
    n_br = m_br; n_tk = m_tk; n_sbr = m_sbr; n_stk = m_stk;
    if (res) begin
      n_br = sat_inc(m_br, 65535);
      n_sbr = sat_inc(m_sbr, 3);
      if (cmp_result) begin
        n_tk = sat_inc(m_tk, 65535);
        n_stk = sat_inc(m_stk, 3);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_seq = n_seq; m_br = n_br; m_tk = n_tk; m_sbr = n_sbr; m_stk = n_stk;
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    model_check(tag);
    advance();
  endtask

  task automatic model_reset();
    m_seq = 0; m_br = 0; m_tk = 0; m_sbr = 0; m_stk = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    //          bv   mode    rs    rt    we   rwe  mte   wm   rwm  mtm  cmp  stl pc fd fa fb
    vecs[0] = '{1'b1, M_BEQ,  5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, M_BNE,  5'd5, 5'd6, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, M_BEQ,  5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, M_BLTZ, 5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, M_BGTZ, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, M_BEQ,  5'd4, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, M_BNE,  5'd9, 5'd4, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, M_NULL, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, M_BLTZ, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{1'b0, M_BEQ,  5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    drive_idle();
    reset_n = 1'b0;
    model_reset();
    #2;
    chk("reset.StallF", {31'd0, StallF}, 32'd0);
    chk("reset.br_count", {16'd0, br_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("idle0");

    // BEQ r3,r3 without hazards resolves in the same cycle
    drive(1'b1, M_BEQ, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("beq0.StallF", {31'd0, StallF}, 32'd0);
    chk("beq0.PCSrcD", {31'd0, PCSrcD}, 32'd1);
    chk("beq0.FlushD", {31'd0, FlushD}, 32'd1);
    model_check("beq0");
    advance();
    drive_idle();
    @(negedge clk);
    chk("beq0.br_count", {16'd0, br_count}, 32'd1);
    chk("beq0.taken_count", {16'd0, taken_count}, 32'd1);
    model_check("beq0_after");
    advance();

    // BNE with EX ALU producer: one stall, then forward from MEM
    drive(1'b1, M_BNE, 5'd5, 5'd6, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bne1.stall", {29'd0, StallF, StallD, FlushE}, 32'd7);
    chk("bne1.PCSrcD0", {31'd0, PCSrcD}, 32'd0);
    model_check("bne1_c0");
    advance();
    drive(1'b1, M_BNE, 5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("bne1.ForwardAD", {31'd0, ForwardAD}, 32'd1);
    chk("bne1.nostall", {31'd0, StallF}, 32'd0);
    chk("bne1.PCSrcD1", {31'd0, PCSrcD}, 32'd1);
    model_check("bne1_c1");
    advance();
    drive_idle();
    step("bne1_after");

    // BEQ with EX load on rt: two stall cycles, resolve on cycle 3
    drive(1'b1, M_BEQ, 5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("beq2.c%0d.StallD", c), {31'd0, StallD}, (c < 2) ? 32'd1 : 32'd0);
      chk($sformatf("beq2.c%0d.PCSrcD", c), {31'd0, PCSrcD}, (c < 2) ? 32'd0 : 32'd1);
      model_check("beq2");
      advance();
      if (c == 0) br_valid = 1'b0;
    end
    drive(1'b1, M_BLTZ, 5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bltz_rt.StallF", {31'd0, StallF}, 32'd0);
    model_check("bltz_rt");
    advance();

    // r0 never creates a dependence or forwarding
    drive(1'b1, M_BEQ, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("r0.StallF", {31'd0, StallF}, 32'd0);
    chk("r0.ForwardAD", {31'd0, ForwardAD}, 32'd0);
    model_check("r0");
    advance();

    // reset during the first stall cycle of a depth-2 branch
    drive(1'b1, M_BEQ, 5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    #2;
    chk("rst.pre_StallF", {31'd0, StallF}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst.outs", {25'd0, StallF, StallD, FlushE, FlushD, PCSrcD, ForwardAD, ForwardBD}, 32'd0);
    chk("rst.br_count", {16'd0, br_count}, 32'd0);
    chk("rst.taken_count", {16'd0, taken_count}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b1, M_BEQ, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rst.idle_resolve", {31'd0, PCSrcD}, 32'd1);
    model_check("rst_post");
    advance();
    drive_idle();
    step("rst_post_idle");

    // table vectors, each applied from IDLE then drained
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].bv, vecs[i].mode, vecs[i].rs, vecs[i].rt, vecs[i].we, vecs[i].rwe,
            vecs[i].mte, vecs[i].wm, vecs[i].rwm, vecs[i].mtm, vecs[i].cmp);
      @(negedge clk);
      chk($sformatf("vec%0d.stall", i), {31'd0, StallF}, {31'd0, vecs[i].e_stall});
      chk($sformatf("vec%0d.PCSrcD", i), {31'd0, PCSrcD}, {31'd0, vecs[i].e_pc});
      chk($sformatf("vec%0d.FlushD", i), {31'd0, FlushD}, {31'd0, vecs[i].e_fd});
      chk($sformatf("vec%0d.ForwardAD", i), {31'd0, ForwardAD}, {31'd0, vecs[i].e_fa});
      chk($sformatf("vec%0d.ForwardBD", i), {31'd0, ForwardBD}, {31'd0, vecs[i].e_fb});
      model_check($sformatf("vec%0d", i));
      advance();
      drive_idle();
      repeat (3) step($sformatf("vec%0d_drain", i));
    end

    // saturation of the 2-bit instance
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, M_BNE, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      step($sformatf("sat%0d", i));
    end
    drive_idle();
    @(negedge clk);
    chk("sat.br_hold", {30'd0, s_br_count}, 32'd3);
    chk("sat.taken_hold", {30'd0, s_taken_count}, 32'd3);
    chk("sat.wide_br", {16'd0, br_count}, 32'd4);
    model_check("sat_after");
    advance();

    // random traffic; the branch in ID is held while a sequence is pending
    begin
      logic [2:0] r_mode;
      logic [4:0] r_rs, r_rt;
      logic       r_rwe, r_rwm;
      r_mode = M_NULL; r_rs = 5'd0; r_rt = 5'd0;
      for (int i = 0; i < 600; i++) begin
        if (m_seq == 0) begin
          r_mode = 3'($urandom_range(0, 4));
          r_rs   = 5'($urandom_range(0, 3));
          r_rt   = 5'($urandom_range(0, 3));
        end
        r_rwe = 1'($urandom_range(0, 1));
        r_rwm = 1'($urandom_range(0, 1));
        drive(($urandom_range(0, 3) != 0), r_mode, r_rs, r_rt,
              5'($urandom_range(0, 3)), r_rwe, r_rwe & 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), r_rwm, r_rwm & 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
        step("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
